// File: rtl/opq_pkg.sv
// Shared definitions for the opcode issue queue: state encoding, decoder widths
// and the occupancy-counter width helper.
package opq_pkg;

  localparam int OP_W_DEF = 7;
  localparam int CTRL_W   = 26;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ACTIVE   = 2'd1,
    FULL     = 2'd2,
    FLUSHING = 2'd3
  } opq_state_e;

  // One extra bit so that count can represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/opq_ram.sv
// DEPTH x OP_W storage array for the issue queue: one write port and one
// asynchronous read port.
module opq_ram #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 7
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [OP_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [OP_W-1:0]          rdata
);

  logic [OP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/opcode_issue_queue.sv
// First-word-fall-through opcode queue feeding the 7-input control decoder from a
// registered head. Define OPQ_BYPASS_EN for a zero-latency path when the queue is empty.
module opcode_issue_queue
  import opq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = OP_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             in_op,
  input  logic                        flush,
  output logic                        dec_valid,
  output logic [OP_W-1:0]             dec_op,
  input  logic                        dec_ack,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic [CNT_W-1:0]            issue_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  opq_state_e      state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OP_W-1:0] head_op_q, head_op_d;
  logic            head_vld_q, head_vld_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  logic            byp_hit;
  logic            byp_take;
  logic            accept;
  logic            pop;
  logic            ram_we;
  logic [OP_W-1:0] ram_rdata;
  logic [CW-1:0]   stay_cnt;

  assign in_ready = !rst && (state_q != FULL) && (state_q != FLUSHING);

`ifdef OPQ_BYPASS_EN
  assign byp_hit = (state_q == EMPTY) && in_valid;
`else
  assign byp_hit = 1'b0;
`endif

  assign dec_valid = head_vld_q || byp_hit;
  assign dec_op    = byp_hit ? in_op : head_op_q;
  assign count     = count_q;
  assign issue_cnt = issue_cnt_q;

  // A bypassed opcode that is acked in the same cycle never touches storage.
  assign byp_take = byp_hit && dec_ack && !flush;
  assign accept   = in_valid && in_ready && !flush;
  assign pop      = head_vld_q && dec_ack && !flush;
  assign ram_we   = accept && !byp_take;
  assign stay_cnt = count_q - CW'(pop);

  opq_ram #(
    .DEPTH (DEPTH),
    .OP_W  (OP_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (in_op),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_op_d   = head_op_q;
    head_vld_d  = head_vld_q;
    issue_cnt_d = issue_cnt_q;

    if (flush) begin
      state_d    = FLUSHING;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      head_vld_d = 1'b0;
      head_op_d  = '0;
    end else begin
      if (ram_we) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (pop || byp_take) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
      count_d    = count_q + CW'(ram_we) - CW'(pop);
      head_vld_d = (count_d != '0);
      // The new head is the incoming opcode only when nothing else remains queued.
      if (count_d != '0) begin
        head_op_d = (ram_we && (stay_cnt == '0)) ? in_op : ram_rdata;
      end

      if (count_d == '0) begin
        state_d = EMPTY;
      end else if (count_d == CW'(DEPTH)) begin
        state_d = FULL;
      end else begin
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_op_q   <= '0;
      head_vld_q  <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_op_q   <= head_op_d;
      head_vld_q  <= head_vld_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

endmodule

// File: tb/tb_opcode_issue_queue.sv
// Self-checking bench for opcode_issue_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model (honours OPQ_BYPASS_EN).
module tb_opcode_issue_queue;

  localparam int DEPTH = 4;
  localparam int OP_W  = 7;
  localparam int CNT_W = 10;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic            flush;
  logic            dec_valid;
  logic [OP_W-1:0] dec_op;
  logic            dec_ack;
  logic [CW-1:0]   count;
  logic [CNT_W-1:0] issue_cnt;

  opcode_issue_queue #(
    .DEPTH (DEPTH),
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .flush     (flush),
    .dec_valid (dec_valid),
    .dec_op    (dec_op),
    .dec_ack   (dec_ack),
    .count     (count),
    .issue_cnt (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue contents, flushing flag, retire counter.
  logic [OP_W-1:0]  mq[$];
  bit               m_flushing;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flushing = 1'b0;
    m_cnt      = '0;
  endtask

  // One clock: drive inputs, compare outputs with the model, clock, update the model.
  task automatic step(input logic v, input logic [OP_W-1:0] op, input logic ack,
                      input logic fl, input bit show);
    logic            ev, er, byp;
    logic [OP_W-1:0] eo;
    int              sz;
    in_valid = v;
    in_op    = op;
    dec_ack  = ack;
    flush    = fl;
    #1;
    sz  = mq.size();
    er  = !m_flushing && (sz < DEPTH);
    ev  = !m_flushing && (sz > 0);
    eo  = (sz > 0) ? mq[0] : '0;
    byp = 1'b0;
`ifdef OPQ_BYPASS_EN
    if (!m_flushing && sz == 0 && v) begin
      byp = 1'b1;
      ev  = 1'b1;
      eo  = op;
    end
`endif
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("dec_valid", 32'(dec_valid), 32'(ev));
    if (ev) chk("dec_op", 32'(dec_op), 32'(eo));
    chk("count", 32'(count), 32'(sz));
    chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    if (show)
      $display("txn t=%0t v=%0b op=%02h ack=%0b fl=%0b | rdy=%0b dv=%0b dop=%02h cnt=%0d icnt=%0d",
               $time, v, op, ack, fl, in_ready, dec_valid, dec_op, count, issue_cnt);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_flushing = 1'b1;
    end else begin
      m_flushing = 1'b0;
      if (ev && ack) m_cnt = m_cnt + 1'b1;
      if (!(byp && ack)) begin
        if (ev && ack) void'(mq.pop_front());
        if (v && er) mq.push_back(op);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [CNT_W-1:0] cnt0;
    int               guard;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; flush = 1'b0; dec_ack = 1'b0;
    model_reset();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_op", 32'(dec_op), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single opcode held while not acked.
    step(1'b1, 7'h15, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
      chk("hold_dec_op", 32'(dec_op), 32'h15);
      chk("hold_count", 32'(count), 32'd1);
    end
    step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);

    // Fill to full, stall a fifth push, admit it after one retire.
    for (int i = 1; i <= 4; i++) step(1'b1, 7'(i), 1'b0, 1'b0, 1'b1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 7'h05, 1'b0, 1'b0, 1'b1);
    step(1'b1, 7'h05, 1'b1, 1'b0, 1'b1);
    step(1'b1, 7'h05, 1'b0, 1'b0, 1'b1);
    chk("refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);
    chk("drained_count", 32'(count), 32'd0);

    // Streaming 20 opcodes with continuous ack.
    cnt0 = issue_cnt;
    for (int i = 0; i <= 20; i++) begin
      step(i < 20, 7'(i), 1'b1, 1'b0, 1'b1);
      if (i >= 1 && i < 20) chk("stream_no_bubble", 32'(dec_valid), 32'd1);
    end
    chk("stream_issue_delta", 32'(issue_cnt - cnt0), 32'd20);

    // Flush with concurrent accept and retire.
    for (int i = 0; i < 3; i++) step(1'b1, 7'h30 + 7'(i), 1'b0, 1'b0, 1'b1);
    cnt0 = issue_cnt;
    step(1'b1, 7'h40, 1'b1, 1'b1, 1'b1);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_issue_cnt", 32'(issue_cnt), 32'(cnt0));
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    chk("post_flush_in_ready", 32'(in_ready), 32'd1);

`ifdef OPQ_BYPASS_EN
    // Zero-latency bypass retire on an empty queue.
    cnt0     = issue_cnt;
    in_valid = 1'b1; in_op = 7'h7F; dec_ack = 1'b1; flush = 1'b0;
    #1;
    chk("byp_dec_op", 32'(dec_op), 32'h7F);
    chk("byp_dec_valid", 32'(dec_valid), 32'd1);
    step(1'b1, 7'h7F, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0; dec_ack = 1'b0;
    #1;
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_issue_cnt", 32'(issue_cnt), 32'(cnt0 + 1'b1));
    @(negedge clk);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3, 0) != 0, 7'($urandom), 1'($urandom),
           $urandom_range(15, 0) == 0, 1'b0);
    end
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

    // Issue counter wrap.
    guard = 0;
    while (m_cnt != '1 && guard < (1 << CNT_W) + 16) begin
      step(1'b1, 7'(guard), 1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("wrap_reached_max", 32'(issue_cnt), 32'((1 << CNT_W) - 1));
    step(1'b1, 7'h11, 1'b1, 1'b0, 1'b1);
    chk("wrap_zero", 32'(issue_cnt), 32'd0);

    // Asynchronous reset in the middle of operation.
    step(1'b1, 7'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 7'h23, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 7'h5A, 1'b0, 1'b0, 1'b1);
    step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
